// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and types for the registered 1:8 demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;
    localparam int NUM_CH    = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_WIDTH = 3;

    typedef logic [SEL_W-1:0] ch_idx_t;
endpackage
`default_nettype wire

// File: rtl/demux_ch_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_ch_reg
// Description : One output channel: data register, valid flag, free flag.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_ch_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_valid,
    output logic             o_free
);
    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;
    logic             r_valid_q;
    logic             w_valid_d;
    logic             w_free;

    // A load on the same edge as a consume keeps the channel valid.
    always_comb begin
        w_free    = !r_valid_q || i_out_ready;
        w_valid_d = i_load || (r_valid_q && !i_out_ready);
        w_data_d  = i_load ? i_d : r_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_y     = r_data_q;
    assign o_valid = r_valid_q;
    assign o_free  = w_free;
endmodule
`default_nettype wire

// File: rtl/demux_1_8_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_8_reg
// Description : Registered 1:8 demux with per-channel valid/ready.
//               Define DEMUX_1_8_RR_EN to route by an internal round-robin
//               pointer (exposed on rr_ptr) instead of s.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_8_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   s,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   y0,
    output logic [WIDTH-1:0]   y1,
    output logic [WIDTH-1:0]   y2,
    output logic [WIDTH-1:0]   y3,
    output logic [WIDTH-1:0]   y4,
    output logic [WIDTH-1:0]   y5,
    output logic [WIDTH-1:0]   y6,
    output logic [WIDTH-1:0]   y7,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready
`ifdef DEMUX_1_8_RR_EN
    ,
    output logic [SEL_W-1:0]   rr_ptr
`endif
);
    ch_idx_t          w_target;
    logic             w_accept;
    logic [NUM_CH-1:0] w_free;
    logic [NUM_CH-1:0] w_load;
    logic [WIDTH-1:0] w_y [NUM_CH];

`ifdef DEMUX_1_8_RR_EN
    ch_idx_t r_ptr_q;
    ch_idx_t w_ptr_d;
    logic    w_unused_s;

    assign w_unused_s = ^s;
    assign w_target   = r_ptr_q;

    // Pointer only moves on an accepted word; wrap 7->0 is natural overflow.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_accept) begin
            w_ptr_d = r_ptr_q + ch_idx_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign rr_ptr = r_ptr_q;
`else
    assign w_target = s;
`endif

    always_comb begin
        in_ready = w_free[w_target];
        w_accept = in_valid && in_ready;
        w_load   = '0;
        if (w_accept) begin
            w_load = NUM_CH'(1) << w_target;
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            demux_ch_reg #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_load     (w_load[k]),
                .i_d        (d),
                .i_out_ready(out_ready[k]),
                .o_y        (w_y[k]),
                .o_valid    (out_valid[k]),
                .o_free     (w_free[k])
            );
        end
    endgenerate

    assign y0 = w_y[0];
    assign y1 = w_y[1];
    assign y2 = w_y[2];
    assign y3 = w_y[3];
    assign y4 = w_y[4];
    assign y5 = w_y[5];
    assign y6 = w_y[6];
    assign y7 = w_y[7];
endmodule
`default_nettype wire
